// File: rtl/viterbi_pkg.sv
// Shared types and constants for the convolutional-code channel stages.
package viterbi_pkg;

  typedef enum logic [1:0] {CH_CLEAN, CH_SCHED, CH_RAND, CH_BOTH} ch_mode_t;
  typedef enum logic [1:0] {B_IDLE, B_BURST, B_DONE} burst_st_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1), advances on adv.
module lfsr16
  import viterbi_pkg::*;
#(
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else if (adv) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/channel_err_inj.sv
// Registered channel model: corrupts code symbols by scheduled burst and/or
// pseudo-random single-bit flips, with saturating error and symbol counters.
module channel_err_inj
  import viterbi_pkg::*;
#(
  parameter int          N    = 3,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          CT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [1:0]      d_in,
  input  logic [1:0]      mode_i,
  input  logic [CT_W-1:0] err_idx_i,
  input  logic [3:0]      burst_len_i,
  output logic            valid_o,
  output logic [1:0]      d_out,
  output logic [1:0]      err_inj,
  output logic [CT_W-1:0] bad_bit_ct,
  output logic [CT_W-1:0] word_ct,
  output logic            burst_done
);

  localparam int CW1 = CT_W + 1;

  ch_mode_t        mode;
  burst_st_t       st;
  logic [3:0]      rem;
  logic [15:0]     lfsr;
  logic            sched_en;
  logic            rand_en;
  logic            trig;
  logic [1:0]      m_sched;
  logic [1:0]      m_rand;
  logic [1:0]      mask;
  logic [CT_W:0]   bad_sum;
  logic [CT_W-1:0] bad_next;
  logic [CT_W-1:0] word_next;
  logic            unused_lfsr;

  lfsr16 #(.seed(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (valid_i),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign mode        = ch_mode_t'(mode_i);

  always_comb begin
    sched_en = (mode == CH_SCHED) || (mode == CH_BOTH);
    rand_en  = (mode == CH_RAND)  || (mode == CH_BOTH);

    m_rand = 2'b00;
    if (rand_en && (lfsr[N-1:0] == '0)) begin
      m_rand = lfsr[N] ? 2'b10 : 2'b01;
    end

    // The trigger symbol itself is already part of the burst.
    trig    = (st == B_IDLE) && (word_ct == err_idx_i) && (burst_len_i != 4'd0);
    m_sched = (sched_en && (trig || (st == B_BURST))) ? 2'b11 : 2'b00;
    mask    = m_sched | m_rand;

    bad_sum   = {1'b0, bad_bit_ct} + CW1'(popcnt2(mask));
    bad_next  = bad_sum[CT_W] ? '1 : bad_sum[CT_W-1:0];
    word_next = (&word_ct) ? word_ct : word_ct + CT_W'(1);
  end

  // rem counts burst symbols still to corrupt, including the current one in BURST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= B_IDLE;
      rem        <= '0;
      valid_o    <= 1'b0;
      d_out      <= '0;
      err_inj    <= '0;
      bad_bit_ct <= '0;
      word_ct    <= '0;
      burst_done <= 1'b0;
    end else begin
      valid_o <= valid_i;
      err_inj <= valid_i ? mask : 2'b00;
      if (valid_i) begin
        d_out      <= d_in ^ mask;
        bad_bit_ct <= bad_next;
        word_ct    <= word_next;
        if (sched_en) begin
          case (st)
            B_IDLE: begin
              if (word_ct == err_idx_i) begin
                if (burst_len_i == 4'd0) begin
                  burst_done <= 1'b1;
                end else if (burst_len_i == 4'd1) begin
                  st         <= B_DONE;
                  burst_done <= 1'b1;
                end else begin
                  st  <= B_BURST;
                  rem <= burst_len_i - 4'd1;
                end
              end
            end
            B_BURST: begin
              rem <= rem - 4'd1;
              if (rem == 4'd1) begin
                st         <= B_DONE;
                burst_done <= 1'b1;
              end
            end
            default: st <= st;
          endcase
        end
      end
    end
  end

endmodule
